register_file_write_scheduler: RTL and testbench

Schedules writes into `general_purpose_register_file`, which has one general write port (`address_3`) and a dedicated stack port that writes register 0. Three writeback requesters (execute, memory load, receive) compete for the general port through round-robin arbitration; a separate stack requester feeds the stack port. A per-register busy scoreboard lets decode detect pending writes.

---
 rtl/register_file_scheduler_pkg.sv | 17 +
 rtl/round_robin_arbiter.sv | 37 +++
 rtl/register_file_write_scheduler.sv | 121 ++++++++++++
 tb/tb_register_file_write_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_scheduler_pkg.sv
// Shared definitions for the register file write scheduler.
//   NUM_WRITE_REQUESTERS : number of requesters competing for the general write port
//   write_requester_t    : requester index names (slice order on the packed request ports)
//   STACK_REGISTER       : register written by the dedicated stack port
package register_file_scheduler_pkg;

  localparam int NUM_WRITE_REQUESTERS = 3;

  typedef enum logic [1:0] {
    EXECUTE = 2'd0,
    LOAD    = 2'd1,
    RECEIVE = 2'd2
  } write_requester_t;

  localparam int STACK_REGISTER = 0;

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter, purely combinational.
//   request      : raw request vector
//   eligible     : mask; a request is considered only where its mask bit is 1
//   pointer      : index where the search starts (highest priority this cycle)
//   grant        : one-hot grant, or zero when nothing is eligible
//   next_pointer : granted index + 1 (mod N), or pointer unchanged when no grant
module round_robin_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_pointer
);

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves a value unassigned, which would infer a latch.
    int  idx;
    logic found;
    idx          = 0;
    found        = 1'b0;
    grant        = '0;
    next_pointer = pointer;
    for (int k = 0; k < N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!found && request[idx] && eligible[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        next_pointer = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/register_file_write_scheduler.sv
// Write scheduler for general_purpose_register_file.
//   request_valid/address/data : three writeback requesters (execute, load, receive)
//   request_ready              : combinational round-robin grant, one-hot or zero
//   stack_valid/data/ready     : stack port writing register 0, always accepted
//   reserve_enable/address     : decode reserves a destination register
//   reserve_blocked            : reservation target is already busy
//   register_busy              : registered per-register pending-write scoreboard
//   general_register_write_enable, address_3, general_register_write_data :
//                                registered general-port drive (grant + 1 cycle)
//   stack_write_enable, stack_register_write_data :
//                                registered stack-port drive (valid + 1 cycle)
module register_file_write_scheduler
  import register_file_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH_RF = 3,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_WRITE_REQUESTERS-1:0]              request_valid,
  input  logic [NUM_WRITE_REQUESTERS*ADDR_WIDTH_RF-1:0] request_address,
  input  logic [NUM_WRITE_REQUESTERS*DATA_WIDTH-1:0]   request_data,
  output logic [NUM_WRITE_REQUESTERS-1:0]              request_ready,
  input  logic                                         stack_valid,
  input  logic [DATA_WIDTH-1:0]                        stack_data,
  output logic                                         stack_ready,
  input  logic                                         reserve_enable,
  input  logic [ADDR_WIDTH_RF-1:0]                     reserve_address,
  output logic                                         reserve_blocked,
  output logic [2**ADDR_WIDTH_RF-1:0]                  register_busy,
  output logic                                         general_register_write_enable,
  output logic [ADDR_WIDTH_RF-1:0]                     address_3,
  output logic [DATA_WIDTH-1:0]                        general_register_write_data,
  output logic                                         stack_write_enable,
  output logic [DATA_WIDTH-1:0]                        stack_register_write_data
);

  localparam int NUM_REGS = 2**ADDR_WIDTH_RF;
  localparam int PTR_W    = $clog2(NUM_WRITE_REQUESTERS);

  logic [NUM_WRITE_REQUESTERS-1:0] eligible;
  logic [NUM_WRITE_REQUESTERS-1:0] grant;
  logic [PTR_W-1:0]                rr_pointer;
  logic [PTR_W-1:0]                next_pointer;
  logic [ADDR_WIDTH_RF-1:0]        grant_address;
  logic [DATA_WIDTH-1:0]           grant_data;
  logic [NUM_REGS-1:0]             busy_next;

  // A requester aiming at the stack register loses to a concurrent stack write.
  // Masking it out (rather than granting and dropping) keeps the pointer in
  // place, so it retains its round-robin position for the retry.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_WRITE_REQUESTERS; i++) begin
      eligible[i] = !(stack_valid &&
                      request_address[i*ADDR_WIDTH_RF +: ADDR_WIDTH_RF] == ADDR_WIDTH_RF'(STACK_REGISTER));
    end
  end

  round_robin_arbiter #(
    .N  (NUM_WRITE_REQUESTERS),
    .PW (PTR_W)
  ) u_arbiter (
    .request      (request_valid),
    .eligible     (eligible),
    .pointer      (rr_pointer),
    .grant        (grant),
    .next_pointer (next_pointer)
  );

  // One-hot grant selects the winning address/data by AND-OR.
  always_comb begin
    grant_address = '0;
    grant_data    = '0;
    for (int i = 0; i < NUM_WRITE_REQUESTERS; i++) begin
      if (grant[i]) begin
        grant_address = grant_address | request_address[i*ADDR_WIDTH_RF +: ADDR_WIDTH_RF];
        grant_data    = grant_data    | request_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Clear first, then set, so a same-cycle reservation of the register being
  // written leaves it busy.
  always_comb begin
    busy_next = register_busy;
    if (|grant)         busy_next[grant_address]   = 1'b0;
    if (reserve_enable) busy_next[reserve_address] = 1'b1;
  end

  assign request_ready   = grant;
  assign stack_ready     = 1'b1;
  assign reserve_blocked = reserve_enable & register_busy[reserve_address];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_pointer                    <= '0;
      register_busy                 <= '0;
      general_register_write_enable <= 1'b0;
      address_3                     <= '0;
      general_register_write_data   <= '0;
      stack_write_enable            <= 1'b0;
      stack_register_write_data     <= '0;
    end else begin
      rr_pointer                    <= next_pointer;
      register_busy                 <= busy_next;
      general_register_write_enable <= |grant;
      if (|grant) begin
        address_3                   <= grant_address;
        general_register_write_data <= grant_data;
      end
      stack_write_enable            <= stack_valid;
      if (stack_valid) begin
        stack_register_write_data   <= stack_data;
      end
    end
  end

endmodule

// File: tb/tb_register_file_write_scheduler.sv
// Self-checking bench for register_file_write_scheduler: directed steps with a
// scoreboard of expected register-file writes (queued at grant, popped at write).
module tb_register_file_write_scheduler;
  import register_file_scheduler_pkg::*;

  localparam int A  = 3;
  localparam int D  = 8;
  localparam int NR = 2**A;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    request_valid;
  logic [3*A-1:0] request_address;
  logic [3*D-1:0] request_data;
  logic [2:0]    request_ready;
  logic          stack_valid;
  logic [D-1:0]  stack_data;
  logic          stack_ready;
  logic          reserve_enable;
  logic [A-1:0]  reserve_address;
  logic          reserve_blocked;
  logic [NR-1:0] register_busy;
  logic          general_register_write_enable;
  logic [A-1:0]  address_3;
  logic [D-1:0]  general_register_write_data;
  logic          stack_write_enable;
  logic [D-1:0]  stack_register_write_data;

  int checks = 0;
  int errors = 0;

  logic [A+D-1:0] gen_q[$];
  logic [D-1:0]   stack_q[$];
  logic [NR-1:0]  exp_busy;

  register_file_write_scheduler #(.ADDR_WIDTH_RF(A), .DATA_WIDTH(D)) dut (
    .clk                           (clk),
    .reset_n                       (reset_n),
    .request_valid                 (request_valid),
    .request_address               (request_address),
    .request_data                  (request_data),
    .request_ready                 (request_ready),
    .stack_valid                   (stack_valid),
    .stack_data                    (stack_data),
    .stack_ready                   (stack_ready),
    .reserve_enable                (reserve_enable),
    .reserve_address               (reserve_address),
    .reserve_blocked               (reserve_blocked),
    .register_busy                 (register_busy),
    .general_register_write_enable (general_register_write_enable),
    .address_3                     (address_3),
    .general_register_write_data   (general_register_write_data),
    .stack_write_enable            (stack_write_enable),
    .stack_register_write_data     (stack_register_write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_req(input write_requester_t r, input logic [A-1:0] a, input logic [D-1:0] d);
    request_address[int'(r)*A +: A] = a;
    request_data[int'(r)*D +: D]    = d;
  endtask

  // Entered just after a rising edge with inputs already applied; returns just
  // after the following rising edge with the resulting writes checked.
  task automatic cycle(input logic [2:0] exp_ready, input logic exp_blocked);
    logic [NR-1:0]  nb;
    logic [A+D-1:0] ent;
    logic [D-1:0]   sd;
    #1;
    check("request_ready", 32'(request_ready), 32'(exp_ready));
    check("reserve_blocked", 32'(reserve_blocked), 32'(exp_blocked));
    nb = exp_busy;
    for (int i = 0; i < 3; i++) begin
      if (exp_ready[i]) begin
        ent = {request_address[i*A +: A], request_data[i*D +: D]};
        gen_q.push_back(ent);
        nb[ent[A+D-1:D]] = 1'b0;
      end
    end
    if (reserve_enable) nb[reserve_address] = 1'b1;
    if (stack_valid) stack_q.push_back(stack_data);
    @(posedge clk);
    #1;
    exp_busy = nb;
    check("gen_write_enable", 32'(general_register_write_enable), 32'(gen_q.size() != 0));
    if (gen_q.size() != 0) begin
      ent = gen_q.pop_front();
      check("address_3", 32'(address_3), 32'(ent[A+D-1:D]));
      check("gen_write_data", 32'(general_register_write_data), 32'(ent[D-1:0]));
    end
    check("stack_write_enable", 32'(stack_write_enable), 32'(stack_q.size() != 0));
    if (stack_q.size() != 0) begin
      sd = stack_q.pop_front();
      check("stack_write_data", 32'(stack_register_write_data), 32'(sd));
    end
    check("register_busy", 32'(register_busy), 32'(exp_busy));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gen_we"}, 32'(general_register_write_enable), 32'd0);
    check({tag, "_address_3"}, 32'(address_3), 32'd0);
    check({tag, "_gen_data"}, 32'(general_register_write_data), 32'd0);
    check({tag, "_stack_we"}, 32'(stack_write_enable), 32'd0);
    check({tag, "_stack_data"}, 32'(stack_register_write_data), 32'd0);
    check({tag, "_busy"}, 32'(register_busy), 32'd0);
  endtask

  initial begin
    reset_n         = 1'b0;
    request_valid   = '0;
    request_address = '0;
    request_data    = '0;
    stack_valid     = 1'b0;
    stack_data      = '0;
    reserve_enable  = 1'b0;
    reserve_address = '0;
    exp_busy        = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    check("stack_ready", 32'(stack_ready), 32'd1);
    reset_n = 1'b1;

    // Round-robin fairness: execute, load, receive, execute
    request_valid = 3'b111;
    set_req(EXECUTE, 3'd1, 8'h11);
    set_req(LOAD,    3'd2, 8'h22);
    set_req(RECEIVE, 3'd3, 8'h33);
    cycle(3'b001, 1'b0);
    cycle(3'b010, 1'b0);
    cycle(3'b100, 1'b0);
    cycle(3'b001, 1'b0);

    // Keep traffic going and reserve r6 so there is state for reset to clear
    reserve_enable  = 1'b1;
    reserve_address = 3'd6;
    cycle(3'b010, 1'b0);
    reserve_enable  = 1'b0;

    // Asynchronous reset mid-traffic; the grant pending at the edge is dropped
    #1;
    reset_n = 1'b0;
    #1;
    gen_q.delete();
    stack_q.delete();
    exp_busy = '0;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    reset_n = 1'b1;
    cycle(3'b001, 1'b0);

    // Stack conflict: load to r0 is deferred while the stack writes
    request_valid = 3'b010;
    set_req(LOAD, 3'd0, 8'h55);
    stack_valid = 1'b1;
    stack_data  = 8'hAA;
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    stack_valid = 1'b0;
    cycle(3'b010, 1'b0);

    // Simultaneous general and stack writes
    request_valid = 3'b001;
    set_req(EXECUTE, 3'd5, 8'hF0);
    stack_valid = 1'b1;
    stack_data  = 8'h0F;
    cycle(3'b001, 1'b0);
    stack_valid   = 1'b0;
    request_valid = 3'b000;

    // Scoreboard: reserve, blocked re-reserve, clear by write, set wins
    reserve_enable  = 1'b1;
    reserve_address = 3'd4;
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b1);
    reserve_enable = 1'b0;
    request_valid  = 3'b100;
    set_req(RECEIVE, 3'd4, 8'h44);
    cycle(3'b100, 1'b0);
    set_req(RECEIVE, 3'd4, 8'h45);
    reserve_enable = 1'b1;
    cycle(3'b100, 1'b0);
    reserve_enable = 1'b0;
    request_valid  = 3'b000;

    // Idle: no writes, then pointer still at execute
    for (int i = 0; i < 5; i++) cycle(3'b000, 1'b0);
    request_valid = 3'b111;
    set_req(EXECUTE, 3'd1, 8'h11);
    set_req(LOAD,    3'd2, 8'h22);
    set_req(RECEIVE, 3'd3, 8'h33);
    cycle(3'b001, 1'b0);
    request_valid = 3'b000;
    cycle(3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
